// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared AXIS widths, arbiter FSM encoding and clog2 helper for the Ethernet TX path
package eth_tx_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  // ceil(log2(value)); clog2(1) = 0
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot round-robin pick starting at a pointer, wrapping upward
module rr_arbiter #(
  parameter int P_N     = 4,
  parameter int P_IDX_W = 2
) (
  input  logic [P_N-1:0]     i_req,
  input  logic [P_IDX_W-1:0] i_ptr,
  output logic [P_N-1:0]     o_grant,
  output logic [P_IDX_W-1:0] o_idx,
  output logic               o_any
);

  // scan i_ptr, i_ptr+1, ... (mod P_N) and take the first requester
  always_comb begin
    logic [P_IDX_W:0]   w_sum;
    logic [P_IDX_W-1:0] w_k;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_k     = '0;
    for (int off = 0; off < P_N; off++) begin
      w_sum = {1'b0, i_ptr} + (P_IDX_W+1)'(off);
      if (w_sum >= (P_IDX_W+1)'(P_N)) begin
        w_sum = w_sum - (P_IDX_W+1)'(P_N);
      end
      w_k = w_sum[P_IDX_W-1:0];
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - frame-granular round-robin TX arbiter with IFG and truncation; TX_ARB_STATS_EN adds frame/trunc counters
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int P_NUM_SRC    = 4,
  parameter int P_IFG_CYCLES = 2,
  parameter int P_MAX_BEATS  = 1518
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [AXIS_DATA_W*P_NUM_SRC-1:0] i_s_axis_tdata,
  input  logic [AXIS_KEEP_W*P_NUM_SRC-1:0] i_s_axis_tkeep,
  input  logic [P_NUM_SRC-1:0]             i_s_axis_tlast,
  input  logic [P_NUM_SRC-1:0]             i_s_axis_tvalid,
  output logic [P_NUM_SRC-1:0]             o_s_axis_tready,
  output logic [AXIS_DATA_W-1:0]           o_m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]           o_m_axis_tkeep,
  output logic                             o_m_axis_tlast,
  output logic                             o_m_axis_tuser,
  output logic                             o_m_axis_tvalid,
  input  logic                             i_m_axis_tready,
  output logic [P_NUM_SRC-1:0]             o_grant,
  output logic                             o_trunc_err
`ifdef TX_ARB_STATS_EN
  ,
  output logic [32*P_NUM_SRC-1:0]          o_frame_cnt,
  output logic [15:0]                      o_trunc_cnt
`endif
);

  localparam int L_IDX_W  = clog2(P_NUM_SRC);
  localparam int L_BEAT_W = clog2(P_MAX_BEATS + 1);
  localparam int L_GAP_W  = (P_IFG_CYCLES > 1) ? clog2(P_IFG_CYCLES) : 1;
  localparam logic [L_BEAT_W-1:0] L_BEAT_LAST = L_BEAT_W'(P_MAX_BEATS - 1);
  localparam logic [L_GAP_W-1:0]  L_GAP_LAST  = L_GAP_W'((P_IFG_CYCLES > 0) ? P_IFG_CYCLES - 1 : 0);
  localparam tx_state_e L_AFTER_FRAME = (P_IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

  tx_state_e               r_state;
  tx_state_e               w_state_nxt;
  logic [P_NUM_SRC-1:0]    r_grant;
  logic [P_NUM_SRC-1:0]    w_pick;
  logic [L_IDX_W-1:0]      r_idx;
  logic [L_IDX_W-1:0]      r_ptr;
  logic [L_IDX_W-1:0]      w_pick_idx;
  logic [L_IDX_W-1:0]      w_ptr_nxt;
  logic                    w_any;
  logic [L_BEAT_W-1:0]     r_beat;
  logic [L_GAP_W-1:0]      r_gap;
  logic [AXIS_DATA_W-1:0]  w_src_tdata;
  logic [AXIS_KEEP_W-1:0]  w_src_tkeep;
  logic                    w_src_tvalid;
  logic                    w_src_tlast;
  logic                    w_trunc_beat;
  logic                    w_hs;
  logic                    w_trunc;
  logic                    w_frame_end;

  rr_arbiter #(
    .P_N     (P_NUM_SRC),
    .P_IDX_W (L_IDX_W)
  ) u_rr (
    .i_req   (i_s_axis_tvalid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  assign w_src_tvalid = |(i_s_axis_tvalid & r_grant);
  assign w_src_tlast  = |(i_s_axis_tlast & r_grant);
  assign w_trunc_beat = (r_beat == L_BEAT_LAST) && !w_src_tlast;
  assign w_ptr_nxt    = (r_idx == L_IDX_W'(P_NUM_SRC - 1)) ? '0 : r_idx + L_IDX_W'(1);
  assign o_grant      = r_grant;
  assign o_trunc_err  = w_trunc;

  // AND-OR mux of the granted source's data and keep (grant is one-hot or zero)
  always_comb begin
    w_src_tdata = '0;
    w_src_tkeep = '0;
    for (int k = 0; k < P_NUM_SRC; k++) begin
      if (r_grant[k]) begin
        w_src_tdata |= i_s_axis_tdata[k*AXIS_DATA_W +: AXIS_DATA_W];
        w_src_tkeep |= i_s_axis_tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W];
      end
    end
  end

  // next state and all stream-side outputs; everything is quiet outside XFER/DRAIN
  always_comb begin
    w_state_nxt     = r_state;
    o_s_axis_tready = '0;
    o_m_axis_tdata  = '0;
    o_m_axis_tkeep  = '0;
    o_m_axis_tlast  = 1'b0;
    o_m_axis_tuser  = 1'b0;
    o_m_axis_tvalid = 1'b0;
    w_hs            = 1'b0;
    w_trunc         = 1'b0;
    w_frame_end     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        o_m_axis_tvalid = w_src_tvalid;
        o_m_axis_tdata  = w_src_tdata;
        o_m_axis_tkeep  = w_src_tkeep;
        o_m_axis_tuser  = w_src_tvalid && w_trunc_beat;
        o_m_axis_tlast  = w_src_tlast || (w_src_tvalid && w_trunc_beat);
        o_s_axis_tready = i_m_axis_tready ? r_grant : '0;
        w_hs            = w_src_tvalid && i_m_axis_tready;
        if (w_hs && w_src_tlast) begin
          w_frame_end = 1'b1;
          w_state_nxt = L_AFTER_FRAME;
        end else if (w_hs && w_trunc_beat) begin
          w_trunc     = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // swallow the rest of the runaway frame without presenting it to the MAC
        o_s_axis_tready = r_grant;
        if (w_src_tvalid && w_src_tlast) begin
          w_frame_end = 1'b1;
          w_state_nxt = L_AFTER_FRAME;
        end
      end
      ST_GAP: begin
        if (r_gap == L_GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state, grant/owner latch, rr pointer, beat and gap counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) begin
        r_grant <= w_pick;
        r_idx   <= w_pick_idx;
        r_beat  <= '0;
      end
      if (w_hs) r_beat <= r_beat + L_BEAT_W'(1);
      if (r_state == ST_GAP) r_gap <= r_gap + L_GAP_W'(1);
      if (w_frame_end) begin
        r_ptr   <= w_ptr_nxt;
        r_grant <= '0;
        r_gap   <= '0;
      end
    end
  end

`ifdef TX_ARB_STATS_EN
  logic [31:0] r_frame_cnt [P_NUM_SRC];
  logic [15:0] r_trunc_cnt;

  // per-source completed frames (wrapping) and saturating truncation count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < P_NUM_SRC; k++) r_frame_cnt[k] <= '0;
      r_trunc_cnt <= '0;
    end else begin
      for (int k = 0; k < P_NUM_SRC; k++) begin
        if (w_frame_end && r_grant[k]) r_frame_cnt[k] <= r_frame_cnt[k] + 32'd1;
      end
      if (w_trunc && r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 16'd1;
    end
  end

  // flatten the per-source counters onto the output bus
  always_comb begin
    o_frame_cnt = '0;
    for (int k = 0; k < P_NUM_SRC; k++) o_frame_cnt[k*32 +: 32] = r_frame_cnt[k];
  end

  assign o_trunc_cnt = r_trunc_cnt;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - self-checking bench for eth_tx_arbiter against a frame-level reference model
module tb_eth_tx_arbiter;
  localparam int N    = 4;
  localparam int IFG  = 2;
  localparam int MAXB = 16;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [64*N-1:0] s_tdata  = '0;
  logic [8*N-1:0]  s_tkeep  = '0;
  logic [N-1:0]    s_tlast  = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic            m_tlast, m_tuser, m_tvalid;
  logic            m_tready = 1'b0;
  logic [N-1:0]    grant;
  logic            trunc_err;
`ifdef TX_ARB_STATS_EN
  logic [32*N-1:0] frame_cnt;
  logic [15:0]     trunc_cnt;
`endif

  eth_tx_arbiter #(.P_NUM_SRC(N), .P_IFG_CYCLES(IFG), .P_MAX_BEATS(MAXB)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tdata  (s_tdata),
    .i_s_axis_tkeep  (s_tkeep),
    .i_s_axis_tlast  (s_tlast),
    .i_s_axis_tvalid (s_tvalid),
    .o_s_axis_tready (s_tready),
    .o_m_axis_tdata  (m_tdata),
    .o_m_axis_tkeep  (m_tkeep),
    .o_m_axis_tlast  (m_tlast),
    .o_m_axis_tuser  (m_tuser),
    .o_m_axis_tvalid (m_tvalid),
    .i_m_axis_tready (m_tready),
    .o_grant         (grant),
    .o_trunc_err     (trunc_err)
`ifdef TX_ARB_STATS_EN
    ,
    .o_frame_cnt     (frame_cnt),
    .o_trunc_cnt     (trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // source drivers
  int frames_left[N];
  int beat_idx[N];
  int cur_len[N];
  int fix_len[N];
  int bubble_pct = 0;
  int mready_pct = 100;
  logic [N-1:0] hs_prev = '0;
  bit rst_req = 1'b0;

  // reference model: owner (-1 = none), rr pointer, cycles since frame end, beats of current frame
  int mdl_owner = -1;
  int mdl_ptr   = 0;
  int mdl_gap   = IFG;
  int mdl_beats = 0;
  int stat_frames[N];
  int stat_trunc = 0;
  int trunc_pulses = 0;
  int m_beats_out = 0;
  int gseq[$];
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tdata"},   m_tdata,          64'd0);
    chk({tag, "_tkeep"},   64'(m_tkeep),     64'd0);
    chk({tag, "_tlast"},   64'(m_tlast),     64'd0);
    chk({tag, "_tuser"},   64'(m_tuser),     64'd0);
    chk({tag, "_tvalid"},  64'(m_tvalid),    64'd0);
    chk({tag, "_grant"},   64'(grant),       64'd0);
    chk({tag, "_s_tready"},64'(s_tready),    64'd0);
    chk({tag, "_trunc"},   64'(trunc_err),   64'd0);
  endtask

  task automatic chk_stats(input string tag);
`ifdef TX_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk({tag, "_frame_cnt"}, 64'(frame_cnt[k*32 +: 32]), 64'(stat_frames[k]));
    chk({tag, "_trunc_cnt"}, 64'(trunc_cnt), 64'(stat_trunc));
`endif
  endtask

  task automatic drive();
    rst_n = !rst_req;
    for (int k = 0; k < N; k++) begin
      if (hs_prev[k]) begin
        if (s_tlast[k]) begin
          frames_left[k]--;
          beat_idx[k] = 0;
        end else begin
          beat_idx[k]++;
        end
        s_tvalid[k] = 1'b0;
      end
      if (!s_tvalid[k] && frames_left[k] > 0 && int'($urandom_range(0, 99)) >= bubble_pct) begin
        if (beat_idx[k] == 0) cur_len[k] = (fix_len[k] > 0) ? fix_len[k] : int'($urandom_range(1, 20));
        s_tvalid[k] = 1'b1;
        s_tdata[k*64 +: 64] = {$urandom, $urandom};
        s_tlast[k] = (beat_idx[k] == cur_len[k] - 1);
        s_tkeep[k*8 +: 8] = s_tlast[k] ? 8'($urandom_range(1, 255)) : 8'hFF;
      end
    end
    if (mready_pct < 0) m_tready = !m_tready;
    else m_tready = (int'($urandom_range(0, 99)) < mready_pct);
  endtask

  task automatic check_update();
    logic [N-1:0] exp_grant, exp_ready;
    logic exp_mv, exp_user, exp_last, exp_trunc;
    int o;
    int c;
    exp_grant = '0;
    exp_ready = '0;
    exp_mv    = 1'b0;
    exp_user  = 1'b0;
    exp_last  = 1'b0;
    exp_trunc = 1'b0;
    o = mdl_owner;
    if (o >= 0) begin
      exp_grant[o] = 1'b1;
      exp_ready[o] = (mdl_beats >= MAXB) ? 1'b1 : m_tready;
      if (mdl_beats < MAXB && s_tvalid[o]) begin
        exp_mv    = 1'b1;
        exp_user  = (mdl_beats == MAXB - 1) && !s_tlast[o];
        exp_last  = s_tlast[o] || exp_user;
        exp_trunc = exp_user && m_tready;
      end
    end
    chk("grant",     64'(grant),     64'(exp_grant));
    chk("s_tready",  64'(s_tready),  64'(exp_ready));
    chk("m_tvalid",  64'(m_tvalid),  64'(exp_mv));
    chk("m_tuser",   64'(m_tuser),   64'(exp_user));
    chk("trunc_err", 64'(trunc_err), 64'(exp_trunc));
    if (exp_mv) begin
      chk("m_tdata", m_tdata,       s_tdata[o*64 +: 64]);
      chk("m_tkeep", 64'(m_tkeep),  64'(s_tkeep[o*8 +: 8]));
      chk("m_tlast", 64'(m_tlast),  64'(exp_last));
    end
    if (trunc_err === 1'b1) trunc_pulses++;
    if (m_tvalid === 1'b1 && m_tready) m_beats_out++;
    if (grant != '0 && prev_grant == '0) begin
      for (int k = 0; k < N; k++) if (grant[k]) gseq.push_back(k);
    end
    prev_grant = grant;
    hs_prev = s_tvalid & s_tready;
    if (!rst_n) begin
      mdl_owner = -1;
      mdl_ptr   = 0;
      mdl_gap   = IFG;
      mdl_beats = 0;
      stat_trunc = 0;
      for (int k = 0; k < N; k++) begin
        stat_frames[k] = 0;
        frames_left[k] = 0;
        beat_idx[k] = 0;
      end
      s_tvalid = '0;
      s_tlast  = '0;
      hs_prev  = '0;
    end else if (o >= 0) begin
      if (s_tvalid[o] && exp_ready[o]) begin
        mdl_beats++;
        if (exp_trunc) stat_trunc++;
        if (s_tlast[o]) begin
          stat_frames[o]++;
          mdl_ptr   = (o + 1) % N;
          mdl_owner = -1;
          mdl_gap   = 0;
        end
      end
    end else if (mdl_gap >= IFG && s_tvalid != '0) begin
      for (int i = 0; i < N; i++) begin
        c = (mdl_ptr + i) % N;
        if (mdl_owner < 0 && s_tvalid[c]) mdl_owner = c;
      end
      mdl_beats = 0;
    end else begin
      mdl_gap++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  function automatic bit all_done();
    bit d;
    d = (s_tvalid == '0) && (mdl_owner < 0) && (mdl_gap >= IFG);
    for (int k = 0; k < N; k++) if (frames_left[k] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_idle(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (n < 3000 && !all_done());
    chk({tag, "_done_in_budget"}, 64'(n < 3000), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    cycle();
    chk_all_zero("reset");

    // single source 0, 8-beat frame, MAC always ready
    for (int k = 0; k < N; k++) fix_len[k] = 8;
    m_beats_out = 0;
    gseq.delete();
    frames_left[0] = 1;
    run_idle("single");
    chk("single_beats", 64'(m_beats_out), 64'd8);
    chk("single_nseq", 64'(gseq.size()), 64'd1);
    chk("single_owner", 64'((gseq.size() > 0) ? gseq[0] : -1), 64'd0);

    // all four sources, 4-beat frames, two each; rr pointer is 1 after source 0's frame
    for (int k = 0; k < N; k++) begin
      fix_len[k] = 4;
      frames_left[k] = 2;
    end
    gseq.delete();
    run_idle("rr4");
    chk("rr4_nseq", 64'(gseq.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("rr4_seq", 64'((i < gseq.size()) ? gseq[i] : -1), 64'((1 + i) % N));
    chk_stats("rr4");

    // source 2 owns the port under toggling MAC ready while source 1 starts requesting
    gseq.delete();
    fix_len[2] = 6;
    fix_len[1] = 5;
    mready_pct = -1;
    frames_left[2] = 1;
    n = 0;
    while (grant !== 4'b0100 && n < 50) begin
      cycle();
      n++;
    end
    chk("hold_grant2", 64'(grant), 64'(4'b0100));
    frames_left[1] = 1;
    run_idle("hold");
    chk("hold_nseq", 64'(gseq.size()), 64'd2);
    chk("hold_first", 64'((gseq.size() > 0) ? gseq[0] : -1), 64'd2);
    chk("hold_second", 64'((gseq.size() > 1) ? gseq[1] : -1), 64'd1);

    // 20-beat runaway frame from source 1 and an exactly-MAXB frame from source 3
    mready_pct = 100;
    fix_len[1] = 20;
    fix_len[3] = MAXB;
    trunc_pulses = 0;
    frames_left[1] = 1;
    frames_left[3] = 1;
    run_idle("trunc");
    chk("trunc_pulses", 64'(trunc_pulses), 64'd1);
    chk_stats("trunc");

    // randomized lengths, source bubbles and MAC back-pressure
    for (int k = 0; k < N; k++) begin
      fix_len[k] = 0;
      frames_left[k] = 3;
    end
    bubble_pct = 30;
    mready_pct = 70;
    run_idle("random");
    chk_stats("random");

    // reset in the middle of a frame, then competing requests from sources 1 and 3
    bubble_pct = 0;
    mready_pct = 100;
    fix_len[2] = 8;
    frames_left[2] = 1;
    n = 0;
    while (!(mdl_owner == 2 && mdl_beats == 3) && n < 100) begin
      cycle();
      n++;
    end
    chk("midrst_reached", 64'(mdl_owner == 2 && mdl_beats == 3), 64'd1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    chk_all_zero("midrst");
    gseq.delete();
    fix_len[1] = 4;
    fix_len[3] = 4;
    frames_left[1] = 1;
    frames_left[3] = 1;
    run_idle("postrst");
    chk("postrst_nseq", 64'(gseq.size()), 64'd2);
    chk("postrst_first", 64'((gseq.size() > 0) ? gseq[0] : -1), 64'd1);
    chk("postrst_second", 64'((gseq.size() > 1) ? gseq[1] : -1), 64'd3);
    chk_stats("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
